// File: rtl/frame_stat_calc.sv
// Per-frame statistics (max/min/peak-to-peak/sum/mean) over an unsigned sample stream.
// Results are held in output registers behind a valid/ready handshake while the next frame accumulates.
module frame_stat_calc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned LOG2_LEN  = 10,
  parameter int unsigned SUM_W     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_first,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_max,
  output logic [DATA_W-1:0] m_min,
  output logic [DATA_W-1:0] m_ptp,
  output logic [SUM_W-1:0]  m_sum,
  output logic [DATA_W-1:0] m_mean,
  output logic [15:0]       frm_cnt,
  output logic              ovf_err,
  output logic              sof_err,
  input  logic              clr_err
);

  typedef enum logic {WAIT_SOF, ACCUM} state_t;

  state_t              state;
  logic [LOG2_LEN-1:0] cnt;
  logic [DATA_W-1:0]   acc_max;
  logic [DATA_W-1:0]   acc_min;
  logic [SUM_W-1:0]    acc_sum;

  logic [DATA_W-1:0]   fin_max_c;
  logic [DATA_W-1:0]   fin_min_c;
  logic [SUM_W-1:0]    fin_sum_c;
  logic                last_c;
  logic                restart_c;
  logic                publish_c;
  logic                load_c;
  logic                ovf_set_c;
  logic                consume_c;

  // Running stats including the current sample; these are also the final values on the last sample.
  always_comb begin
    fin_max_c = (s_data > acc_max) ? s_data : acc_max;
    fin_min_c = (s_data < acc_min) ? s_data : acc_min;
    fin_sum_c = acc_sum + SUM_W'(s_data);
    last_c    = (cnt == LOG2_LEN'(FRAME_LEN - 1));
    restart_c = s_valid & s_first & (state == ACCUM);
    publish_c = s_valid & ~s_first & (state == ACCUM) & last_c;
    consume_c = m_valid & m_ready;
    load_c    = publish_c & (~m_valid | m_ready);
    ovf_set_c = publish_c & m_valid & ~m_ready;
  end

  // Frame tracking and accumulation; only advances on valid samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_SOF;
      cnt     <= '0;
      acc_max <= '0;
      acc_min <= '0;
      acc_sum <= '0;
    end else if (s_valid) begin
      case (state)
        WAIT_SOF: begin
          if (s_first) begin
            acc_max <= s_data;
            acc_min <= s_data;
            acc_sum <= SUM_W'(s_data);
            cnt     <= LOG2_LEN'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (s_first) begin
            // Early start-of-frame: drop the short frame and restart on this sample.
            acc_max <= s_data;
            acc_min <= s_data;
            acc_sum <= SUM_W'(s_data);
            cnt     <= LOG2_LEN'(1);
          end else if (last_c) begin
            cnt   <= '0;
            state <= WAIT_SOF;
          end else begin
            acc_max <= fin_max_c;
            acc_min <= fin_min_c;
            acc_sum <= fin_sum_c;
            cnt     <= cnt + LOG2_LEN'(1);
          end
        end
      endcase
    end
  end

  // Result holding registers and handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_max   <= '0;
      m_min   <= '0;
      m_ptp   <= '0;
      m_sum   <= '0;
      m_mean  <= '0;
      frm_cnt <= '0;
    end else if (load_c) begin
      m_valid <= 1'b1;
      m_max   <= fin_max_c;
      m_min   <= fin_min_c;
      m_ptp   <= fin_max_c - fin_min_c;
      m_sum   <= fin_sum_c;
      m_mean  <= fin_sum_c[LOG2_LEN +: DATA_W];
      frm_cnt <= frm_cnt + 16'd1;
    end else if (consume_c) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set on the same edge beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      if (ovf_set_c)    ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (restart_c)    sof_err <= 1'b1;
      else if (clr_err) sof_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_stat_calc.sv
// Self-checking bench for frame_stat_calc: directed scenarios plus a randomized run
// against a queue-based frame model.
module tb_frame_stat_calc;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 1024;
  localparam int unsigned LOG2_LEN  = 10;
  localparam int unsigned SUM_W     = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_first, m_ready, clr_err;
  logic [DATA_W-1:0] s_data;
  logic              m_valid, ovf_err, sof_err;
  logic [DATA_W-1:0] m_max, m_min, m_ptp, m_mean;
  logic [SUM_W-1:0]  m_sum;
  logic [15:0]       frm_cnt;

  frame_stat_calc #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .LOG2_LEN(LOG2_LEN), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_first(s_first), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_max(m_max), .m_min(m_min), .m_ptp(m_ptp),
    .m_sum(m_sum), .m_mean(m_mean), .frm_cnt(frm_cnt), .ovf_err(ovf_err), .sof_err(sof_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the open frame is a queue of samples; stats come from plain loops over it.
  int q[$];
  bit in_frame, e_valid, e_ovf, e_sof, known;
  int e_max, e_min, e_sum, e_frm;

  wire [68:0] dut_vec = {m_valid, m_max, m_min, m_ptp, m_sum, m_mean, frm_cnt, ovf_err, sof_err};

  function automatic logic [68:0] exp_vec();
    return {e_valid, 8'(e_max), 8'(e_min), 8'(e_max - e_min), 18'(e_sum), 8'(e_sum / FRAME_LEN),
            16'(e_frm), e_ovf, e_sof};
  endfunction

  // Result data is only defined after reset or while a result is pending.
  function automatic logic [68:0] vec_mask();
    return {1'b1, {50{known}}, 18'h3FFFF};
  endfunction

  task automatic model_reset();
    q.delete();
    in_frame = 0; e_valid = 0; e_ovf = 0; e_sof = 0; known = 1;
    e_max = 0; e_min = 0; e_sum = 0; e_frm = 0;
  endtask

  task automatic model_step(input bit v, input bit f, input int d, input bit rdy, input bit clr);
    bit publish = 0;
    bit ovf_set = 0;
    bit sof_set = 0;
    int mx, mn, sm;
    if (!rst) begin
      model_reset();
      return;
    end
    if (v) begin
      if (!in_frame) begin
        if (f) begin q.delete(); q.push_back(d); in_frame = 1; end
      end else if (f) begin
        sof_set = 1; q.delete(); q.push_back(d);
      end else begin
        q.push_back(d);
        if (q.size() == FRAME_LEN) begin
          publish = 1; in_frame = 0;
          mx = 0; mn = 255; sm = 0;
          foreach (q[i]) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
            sm += q[i];
          end
          q.delete();
        end
      end
    end
    if (publish && (!e_valid || rdy)) begin
      e_valid = 1; known = 1; e_max = mx; e_min = mn; e_sum = sm; e_frm = (e_frm + 1) % 65536;
    end else begin
      if (publish) ovf_set = 1;
      if (e_valid && rdy) begin e_valid = 0; known = 0; end
    end
    if (ovf_set) e_ovf = 1; else if (clr) e_ovf = 0;
    if (sof_set) e_sof = 1; else if (clr) e_sof = 0;
  endtask

  task automatic cyc(input bit v, input bit f, input int d, input bit rdy, input bit clr);
    @(negedge clk);
    s_valid = v; s_first = f; s_data = 8'(d); m_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_step(v, f, d, rdy, clr);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; s_valid = 0; s_first = 0; s_data = 0; m_ready = 0; clr_err = 0;
    model_reset();
    repeat (3) cyc(1, 1, 7, 1, 0);
    checks++;
    if (dut_vec !== 69'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    rst = 1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 1024; i++) begin
      cyc(1, i == 0, i % 256, 1, 0);
      if (i == 1022) begin
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL ramp_early_valid: got %b want 0", m_valid); end
      end
    end
    checks++;
    if ({m_valid, m_max, m_min, m_ptp, m_sum, m_mean, frm_cnt} !== {1'b1, 8'd255, 8'd0, 8'd255, 18'd130560, 8'd127, 16'd1}) begin
      errors++; $display("FAIL ramp_result: got v=%b max=%0d min=%0d ptp=%0d sum=%0d mean=%0d frm=%0d want 1/255/0/255/130560/127/1",
                        m_valid, m_max, m_min, m_ptp, m_sum, m_mean, frm_cnt);
    end
    cyc(0, 0, 0, 1, 0);
    checks++;
    if ((dut_vec & vec_mask()) !== (exp_vec() & vec_mask())) begin
      errors++; $display("FAIL ramp_consumed: got %h want %h", dut_vec & vec_mask(), exp_vec() & vec_mask());
    end
  endtask

  task automatic test_const_gaps();
    int k = 0;
    int early = 0;
    while (k < 1024) begin
      if ($urandom_range(0, 2) == 0) cyc(0, 1'($urandom), int'($urandom_range(0, 255)), 1, 0);
      else begin cyc(1, k == 0, 8'hA5, 1, 0); k++; end
      if (k < 1024 && m_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL gaps_early_valid: got %0d early cycles want 0", early); end
    checks++;
    if ({m_valid, m_max, m_min, m_ptp, m_sum, m_mean} !== {1'b1, 8'hA5, 8'hA5, 8'd0, 18'd168960, 8'hA5}) begin
      errors++; $display("FAIL const_result: got v=%b max=%h min=%h ptp=%h sum=%0d mean=%h want A5/A5/0/168960/A5",
                        m_valid, m_max, m_min, m_ptp, m_sum, m_mean);
    end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_hold_ovf();
    int unstable = 0;
    logic [68:0] want;
    for (int i = 0; i < 1024; i++) cyc(1, i == 0, int'($urandom_range(0, 255)), 0, 0);
    want = exp_vec();
    for (int i = 0; i < 1024; i++) begin
      cyc(1, i == 0, int'($urandom_range(0, 255)), 0, 0);
      if (i < 1023 && dut_vec !== want) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL hold_stable: got %0d changed cycles want 0", unstable); end
    checks++;
    if ({m_valid, ovf_err, frm_cnt} !== {1'b1, 1'b1, 16'd3} || (dut_vec & vec_mask()) !== (exp_vec() & vec_mask())) begin
      errors++; $display("FAIL hold_ovf: got %h want %h", dut_vec, exp_vec());
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    checks++;
    if ({m_valid, frm_cnt} !== {1'b0, 16'd3}) begin
      errors++; $display("FAIL hold_transfer: got v=%b frm=%0d want 0/3", m_valid, frm_cnt);
    end
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
  endtask

  task automatic test_sof();
    for (int i = 0; i < 500; i++) cyc(1, i == 0, int'($urandom_range(0, 255)), 1, 0);
    for (int i = 0; i < 1024; i++) begin
      cyc(1, i == 0, 1, 1, 0);
      if (i == 0) begin
        checks++;
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_set: got %b want 1", sof_err); end
      end
    end
    checks++;
    if ({m_valid, m_sum, m_max, m_min, sof_err} !== {1'b1, 18'd1024, 8'd1, 8'd1, 1'b1}) begin
      errors++; $display("FAIL sof_result: got v=%b sum=%0d max=%0d min=%0d sof=%b want 1/1024/1/1/1",
                        m_valid, m_sum, m_max, m_min, sof_err);
    end
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_clear: got %b want 0", sof_err); end
  endtask

  task automatic test_back_to_back();
    int start = e_frm;
    for (int i = 0; i < 1024; i++) cyc(1, i == 0, int'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 1024; i++) cyc(1, i == 0, int'($urandom_range(0, 255)), i == 1023, 0);
    checks++;
    if ({m_valid, ovf_err} !== 2'b10 || frm_cnt !== 16'(start + 2) || (dut_vec & vec_mask()) !== (exp_vec() & vec_mask())) begin
      errors++; $display("FAIL back_to_back: got %h want %h (frm want %0d)", dut_vec, exp_vec(), start + 2);
    end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    cyc(1, 1, 9, 1, 0);
    cyc(1, 1, 9, 1, 1);
    checks++;
    if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_set_beats_clr: got %b want 1", sof_err); end
    for (int i = 1; i < 700; i++) cyc(1, 0, int'($urandom_range(0, 255)), 1, 0);
    rst = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (dut_vec !== 69'd0) bad++;
      cyc(1, i == 0, 200, 1, 0);
    end
    checks++;
    if (bad != 0 || dut_vec !== 69'd0) begin errors++; $display("FAIL reset_mid_frame: got %h (%0d bad) want 0", dut_vec, bad); end
    rst = 1;
    for (int i = 0; i < 1024; i++) cyc(1, i == 0, 3, 1, 0);
    checks++;
    if ({m_valid, m_sum, frm_cnt} !== {1'b1, 18'd3072, 16'd1} || (dut_vec & vec_mask()) !== (exp_vec() & vec_mask())) begin
      errors++; $display("FAIL after_reset_frame: got v=%b sum=%0d frm=%0d want 1/3072/1", m_valid, m_sum, frm_cnt);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    bit v, f;
    for (int n = 0; n < 5000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      f = in_frame ? ($urandom_range(0, 1499) == 0) : ($urandom_range(0, 3) == 0);
      cyc(v, f, int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
      checks++;
      if ((dut_vec & vec_mask()) !== (exp_vec() & vec_mask())) begin
        errors++;
        if (bad < 5) $display("FAIL random_cycle_%0d: got %h want %h", n, dut_vec & vec_mask(), exp_vec() & vec_mask());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_const_gaps();
    test_hold_ovf();
    test_sof();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
